// File: rtl/spi_byte_master_if.sv
// Host-side handshake of spi_byte_master: byte request, frame delimiter,
// received byte with its one-cycle strobe, and the busy indication.
interface spi_byte_master_if;
   logic       start;
   logic       last;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       redy;
   logic       busy;

   modport master (output start, last, data_in, input data_out, redy, busy);
   modport slave  (input start, last, data_in, output data_out, redy, busy);
endinterface

// File: rtl/spi_byte_master.sv
// Byte-oriented SPI mode-0 initiator, MSB first. Bytes issued with last=0 keep
// SSEL low and wait for the next byte; a byte issued with last=1 closes the frame.
module spi_byte_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   spi_byte_master_if.slave         host,
   output logic                     SCK,
   output logic                     MOSI,
   input  logic                     MISO,
   output logic                     SSEL
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD, S_GAP
   } state_t;

   localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_CNT = (MAX_A > CS_HOLD + 1) ? MAX_A : CS_HOLD + 1;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD);
   localparam logic [CW-1:0] GAP_LAST   = CW'(CS_HOLD - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [6:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    dout_q, dout_d;
   logic          sck_q, sck_d;
   logic          mosi_q, mosi_d;
   logic          ssel_q, ssel_d;
   logic          last_q, last_d;
   logic          redy_q, redy_d;
   logic          load;

   // NOTE: every variable gets a default before the case, so no path leaves one
   // unassigned and no latch can be inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      ssel_d  = ssel_q;
      last_d  = last_q;
      redy_d  = 1'b0;
      load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            ssel_d = 1'b1;
            sck_d  = 1'b0;
            mosi_d = 1'b0;
            cnt_d  = '0;
            if (host.start) begin
               load    = 1'b1;
               ssel_d  = 1'b0;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               sck_d   = 1'b1;
               rx_d    = {rx_q[6:0], MISO};
               state_d = S_XFER;
            end
         end

         S_XFER: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[6:0], MISO};
               end else if (bit_q == 3'd7) begin
                  // Eighth falling edge: the received byte is complete.
                  redy_d  = 1'b1;
                  dout_d  = rx_q;
                  bit_d   = '0;
                  mosi_d  = last_q ? 1'b0 : mosi_q;
                  state_d = last_q ? S_HOLD : S_WAIT;
               end else begin
                  bit_d  = bit_q + 3'd1;
                  mosi_d = tx_q[6];
                  tx_d   = {tx_q[5:0], 1'b0};
               end
            end
         end

         S_WAIT: begin
            cnt_d = '0;
            if (host.start) begin
               load    = 1'b1;
               state_d = S_XFER;
            end
         end

         S_HOLD: begin
            // Entered on the last falling edge, so CS_HOLD further low cycles follow it.
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               ssel_d  = 1'b1;
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            // A start already pending when the gap expires opens the next frame
            // directly, so a held start yields an SSEL-high time of exactly CS_HOLD.
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (host.start) begin
                  load    = 1'b1;
                  ssel_d  = 1'b0;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (load) begin
         tx_d   = host.data_in[6:0];
         mosi_d = host.data_in[7];
         last_d = host.last;
         bit_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before this edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         ssel_q  <= 1'b1;
         last_q  <= 1'b0;
         redy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         ssel_q  <= ssel_d;
         last_q  <= last_d;
         redy_q  <= redy_d;
      end
   end

   assign SCK           = sck_q;
   assign MOSI          = mosi_q;
   assign SSEL          = ssel_q;
   assign host.redy     = redy_q;
   assign host.data_out = dout_q;
   assign host.busy     = state_q inside {S_SETUP, S_XFER, S_HOLD, S_GAP};

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomized scoreboard bench for spi_byte_master: a timing/byte model computed
// from the frame rules, an SPI slave model, and a redy-driven monitor.
module tb_spi_byte_master;

   localparam int D = 4, S = 4, H = 4;
   localparam int FIRST_LAT = 1 + S + 15 * D;   // accept in IDLE -> redy
   localparam int WAIT_LAT  = 1 + 16 * D;       // accept in WAIT -> redy
   localparam int PERIOD    = FIRST_LAT + 2 * H; // frame-to-frame with held start

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic sck, mosi, miso, ssel;
   logic sck_b, mosi_b, miso_b, ssel_b;
   int   cyc = 0;
   int   n_cmp = 0, n_err = 0;

   exp_t       exp_q[$];
   logic [7:0] resp_q[$];
   logic [7:0] cap_q[$];
   int         frame_q[$];
   int         gap_q[$];

   spi_byte_master_if h ();
   spi_byte_master_if hb ();

   spi_byte_master #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H)) dut (
      .clk(clk), .rst_n(rst_n), .host(h),
      .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel));

   spi_byte_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut_min (
      .clk(clk), .rst_n(rst_n), .host(hb),
      .SCK(sck_b), .MOSI(mosi_b), .MISO(miso_b), .SSEL(ssel_b));

   assign miso_b = mosi_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SPI slave model: shifts MOSI in on SCK rising edges, presents the queued
   // response byte MSB first on MISO.
   int         rcnt;
   logic [7:0] mosi_sh = '0;
   always @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         rcnt = 0;
      end else if (!ssel) begin
         mosi_sh = {mosi_sh[6:0], mosi};
         rcnt++;
         if (rcnt == 8) begin
            cap_q.push_back(mosi_sh);
            rcnt = 0;
            if (resp_q.size() > 0) void'(resp_q.pop_front());
         end
      end
   end

   logic [7:0] cur;
   always @(negedge clk) begin
      cur  = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
      miso = cur[3'(7 - rcnt)];
   end

   // Monitor / scoreboard.
   logic prev_redy = 1'b0, prev_sck = 1'b0, prev_ssel = 1'b1;
   int   rise_cnt = 0, rise_cyc = 0, bad_sck = 0;
   bit   have_rise = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      if (sck && ssel) bad_sck++;
      if (!ssel && prev_ssel) begin
         rise_cnt = 0;
         if (have_rise) gap_q.push_back(cyc - rise_cyc);
      end
      if (sck && !prev_sck) rise_cnt++;
      if (ssel && !prev_ssel) begin
         frame_q.push_back(rise_cnt);
         rise_cyc  = cyc;
         have_rise = 1'b1;
      end
      if (h.redy) begin
         check("redy_spacing", prev_redy, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_redy", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("data_out", h.data_out, e.rx);
            check("redy_cycle", cyc, e.cyc);
            if (cap_q.size() == 0) check("mosi_byte_missing", 1'b1, 1'b0);
            else check("mosi_byte", cap_q.pop_front(), e.tx);
         end
      end
      prev_redy = h.redy;
      prev_sck  = sck;
      prev_ssel = ssel;
   end

   task automatic send(input logic [7:0] d, input logic [7:0] r, input bit lst,
                       input bit first, input int dly, output int t0);
      for (int i = 0; i < 2000 && h.busy; i++) @(negedge clk);
      check("start_wait", h.busy, 1'b0);
      repeat (dly) @(negedge clk);
      t0 = cyc;
      h.start   = 1'b1;
      h.data_in = d;
      h.last    = lst;
      resp_q.push_back(r);
      exp_q.push_back('{tx: d, rx: r, cyc: t0 + (first ? FIRST_LAT : WAIT_LAT)});
      @(negedge clk);
      h.start   = 1'b0;
      h.data_in = 8'($urandom);
      h.last    = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && !(ssel && !h.busy); i++) @(negedge clk);
      check("idle_wait", {ssel, h.busy}, 2'b10);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_rises(input string name, input int n);
      if (frame_q.size() == 0) check({name, "_missing"}, 1'b1, 1'b0);
      else check(name, frame_q.pop_front(), n);
   endtask

   int t0, tmp, r1, r2, rdy;
   logic [7:0] dob;
   logic pb;
   logic [7:0] hd [3];
   logic [7:0] hr [3];

   initial begin
      h.start = 0; h.last = 0; h.data_in = 0;
      hb.start = 0; hb.last = 0; hb.data_in = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ssel", ssel, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_busy", h.busy, 1'b0);
      check("rst_redy", h.redy, 1'b0);
      check("rst_data_out", h.data_out, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte with frame-end timing.
      frame_q.delete();
      send(8'hA5, 8'h3C, 1'b1, 1'b1, 0, t0);
      for (int i = 0; i < 200 && !ssel; i++) @(negedge clk);
      check("ssel_rise_cycle", cyc, t0 + FIRST_LAT + H + 1);
      for (int i = 0; i < 200 && h.busy; i++) @(negedge clk);
      check("busy_fall_cycle", cyc, t0 + FIRST_LAT + 2 * H + 1);
      wait_idle();
      check_rises("single_rises", 8);

      // Two-byte frame, second byte issued from WAIT.
      send(8'h81, 8'hD2, 1'b0, 1'b1, 0, t0);
      send(8'h7E, 8'h4B, 1'b1, 1'b0, 1, t0);
      wait_idle();
      check_rises("two_byte_rises", 16);

      // Start while busy is ignored.
      send(8'h3A, 8'h96, 1'b1, 1'b1, 0, t0);
      for (int i = 0; i < 200 && rise_cnt < 2; i++) begin @(negedge clk); #1; end
      h.start = 1'b1; h.data_in = 8'hFF; h.last = 1'b0;
      @(negedge clk);
      h.start = 1'b0;
      wait_idle();
      check_rises("busy_start_rises", 8);
      check("busy_start_drained", exp_q.size(), 0);

      // Asynchronous reset after the third rising edge.
      send(8'hC3, 8'h99, 1'b1, 1'b1, 0, t0);
      for (int i = 0; i < 200 && rise_cnt < 3; i++) begin @(negedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst_ssel", ssel, 1'b1);
      check("midrst_sck", sck, 1'b0);
      check("midrst_mosi", mosi, 1'b0);
      check("midrst_data_out", h.data_out, 8'h00);
      check("midrst_busy", h.busy, 1'b0);
      exp_q.delete(); resp_q.delete(); cap_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      frame_q.delete();
      send(8'($urandom), 8'($urandom), 1'b1, 1'b1, 0, t0);
      wait_idle();
      check_rises("post_reset_rises", 8);

      // Back-to-back frames with start held high.
      frame_q.delete();
      for (int k = 0; k < 3; k++) begin
         hd[k] = 8'($urandom);
         hr[k] = 8'($urandom);
      end
      t0 = cyc;
      h.start = 1'b1; h.last = 1'b1; h.data_in = hd[0];
      for (int k = 0; k < 3; k++) begin
         resp_q.push_back(hr[k]);
         exp_q.push_back('{tx: hd[k], rx: hr[k], cyc: t0 + k * PERIOD + FIRST_LAT});
      end
      repeat (2) @(negedge clk);
      gap_q.delete();
      repeat (PERIOD - 2) @(negedge clk);
      h.data_in = hd[1];
      repeat (PERIOD) @(negedge clk);
      h.data_in = hd[2];
      @(negedge clk);
      h.start = 1'b0;
      wait_idle();
      check("held_gap_count", gap_q.size(), 2);
      while (gap_q.size() > 0) check("held_ssel_gap", gap_q.pop_front(), H);
      for (int k = 0; k < 3; k++) check_rises("held_rises", 8);

      // Randomized frames of 1..3 bytes.
      for (int f = 0; f < 8; f++) begin
         tmp = $urandom_range(1, 3);
         for (int b = 0; b < tmp; b++)
            send(8'($urandom), 8'($urandom), 1'(b == tmp - 1), 1'(b == 0),
                 $urandom_range(0, 3), t0);
         wait_idle();
      end
      check("scoreboard_drained", exp_q.size(), 0);

      // Minimum divider instance, MISO looped back from MOSI.
      @(negedge clk);
      t0 = cyc;
      hb.start = 1'b1; hb.data_in = 8'h5A; hb.last = 1'b1;
      @(negedge clk);
      hb.start = 1'b0;
      r1 = -1; r2 = -1; rdy = -1; dob = '0; pb = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sck_b && !pb) begin
            if (r1 < 0) r1 = cyc;
            else if (r2 < 0) r2 = cyc;
         end
         if (hb.redy && rdy < 0) begin
            rdy = cyc;
            dob = hb.data_out;
         end
         pb = sck_b;
         @(negedge clk);
      end
      check("min_first_rise", r1, t0 + 2);
      check("min_sck_period", r2 - r1, 4);
      check("min_redy_cycle", rdy, t0 + 32);
      check("min_loopback", dob, 8'h5A);
      check("min_idle", {ssel_b, hb.busy}, 2'b10);

      check("sck_high_while_ssel_high", bad_sck, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
